// File: rtl/axis_pkg.sv
// ============================================================================
// Module : axis_pkg
// Brief  : Shared constants and LFSR step function for the AXI-Stream checker.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axis_pkg;

  localparam int AXIS_WIDTH_DEFAULT = 32;

  localparam logic [1:0] RDY_ALWAYS = 2'b00;
  localparam logic [1:0] RDY_ALT    = 2'b01;
  localparam logic [1:0] RDY_LFSR   = 2'b10;
  localparam logic [1:0] RDY_NEVER  = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SYNC  = 2'b01;
  localparam logic [1:0] ST_CHECK = 2'b10;

  // Right-shifting Fibonacci form of the x^16+x^14+x^13+x^11+1 polynomial.
  function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/axis_lfsr16.sv
// ============================================================================
// Module : axis_lfsr16
// Brief  : 16-bit Fibonacci LFSR that steps only when advance is high.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_lfsr16
  import axis_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  output logic [15:0] state
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  always_comb begin
    state_d = state_q;
    if (advance) begin
      state_d = lfsr16_next(state_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

`default_nettype wire

// File: rtl/axis_seq_checker.sv
// ============================================================================
// Module : axis_seq_checker
// Brief  : AXI-Stream sink with programmable backpressure that checks for a
//          +1 incrementing data sequence and reports counts and captures.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_seq_checker
  import axis_pkg::*;
#(
  parameter int          AXIS_WIDTH  = AXIS_WIDTH_DEFAULT,
  parameter int          COUNT_WIDTH = 32,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   clear,
  input  logic [1:0]             ready_mode,
  input  logic                   s_axis_tvalid,
  input  logic [AXIS_WIDTH-1:0]  s_axis_tdata,
  output logic                   s_axis_tready,
  output logic [COUNT_WIDTH-1:0] beat_count,
  output logic [COUNT_WIDTH-1:0] err_count,
  output logic                   err_flag,
  output logic [AXIS_WIDTH-1:0]  first_data,
  output logic [AXIS_WIDTH-1:0]  last_data
);

  logic [1:0]             state_q, state_d;
  logic                   tready_q, tready_d;
  logic [AXIS_WIDTH-1:0]  expected_q, expected_d;
  logic [AXIS_WIDTH-1:0]  first_q, first_d;
  logic [AXIS_WIDTH-1:0]  last_q, last_d;
  logic [COUNT_WIDTH-1:0] beat_q, beat_d;
  logic [COUNT_WIDTH-1:0] err_q, err_d;
  logic                   err_flag_q, err_flag_d;
  logic [15:0]            lfsr_state;
  logic                   lfsr_unused;
  logic                   accept;

  assign accept = s_axis_tvalid & tready_q & (state_q != ST_IDLE);

  axis_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (state_q != ST_IDLE),
    .state   (lfsr_state)
  );

  // Only bit 0 drives ready; the upper bits exist for other consumers.
  assign lfsr_unused = ^lfsr_state[15:1];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (en) state_d = ST_SYNC;
      ST_SYNC: begin
        if (!en)         state_d = ST_IDLE;
        else if (accept) state_d = ST_CHECK;
      end
      ST_CHECK: if (!en) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Ready follows the state being entered, so it drops the cycle after en=0.
  always_comb begin
    tready_d = 1'b0;
    if (state_d != ST_IDLE) begin
      case (ready_mode)
        RDY_ALWAYS: tready_d = 1'b1;
        RDY_ALT:    tready_d = (state_q == ST_IDLE) ? 1'b1 : ~tready_q;
        RDY_LFSR:   tready_d = lfsr_state[0];
        default:    tready_d = 1'b0;
      endcase
    end
  end

  always_comb begin
    expected_d = expected_q;
    first_d    = first_q;
    last_d     = last_q;
    beat_d     = beat_q;
    err_d      = err_q;
    err_flag_d = err_flag_q;
    if (accept) begin
      last_d     = s_axis_tdata;
      expected_d = s_axis_tdata + AXIS_WIDTH'(1);
      if (beat_q != '1) beat_d = beat_q + COUNT_WIDTH'(1);
      if (state_q == ST_SYNC) begin
        first_d = s_axis_tdata;
      end else if (s_axis_tdata != expected_q) begin
        if (err_q != '1) err_d = err_q + COUNT_WIDTH'(1);
        err_flag_d = 1'b1;
      end
    end
    if (clear) begin
      beat_d     = '0;
      err_d      = '0;
      err_flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tready_q   <= 1'b0;
      expected_q <= '0;
      first_q    <= '0;
      last_q     <= '0;
      beat_q     <= '0;
      err_q      <= '0;
      err_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tready_q   <= tready_d;
      expected_q <= expected_d;
      first_q    <= first_d;
      last_q     <= last_d;
      beat_q     <= beat_d;
      err_q      <= err_d;
      err_flag_q <= err_flag_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign beat_count    = beat_q;
  assign err_count     = err_q;
  assign err_flag      = err_flag_q;
  assign first_data    = first_q;
  assign last_data     = last_q;

endmodule

`default_nettype wire
